// File: rtl/drive_enve_pkg.sv
// Shared types and default widths for the drive-circuit envelope-memory address generator.
package drive_enve_pkg;

  localparam int ENVE_ADDR_WIDTH_DEF = 8;
  localparam int ENVE_LEN_WIDTH_DEF  = 8;
  localparam int ENVE_DEPTH_DEF      = 256;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    READ,
    FIN
  } enve_state_t;

  typedef struct packed {
    logic [ENVE_ADDR_WIDTH_DEF-1:0] start;
    logic [ENVE_LEN_WIDTH_DEF-1:0]  len;
  } enve_desc_t;

  // A zero-length descriptor completes immediately without producing addresses.
  function automatic logic desc_is_empty(input enve_desc_t d);
    return (d.len == '0);
  endfunction

endpackage

// File: rtl/drive_enve_addr_gen_desc_buffer.sv
// One-deep pending descriptor register: last write wins, flags overwrites, cleared on promote.
module drive_enve_desc_buffer
  import drive_enve_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  enve_desc_t push_desc,
  input  logic       pop,
  output logic       valid,
  output enve_desc_t head_desc,
  output logic       ovf
);

  enve_desc_t stored_desc;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid       <= 1'b0;
      stored_desc <= '0;
    end else begin
      if (push) begin
        stored_desc <= push_desc;
      end
      if (pop) begin
        valid <= 1'b0;
      end else if (push) begin
        valid <= 1'b1;
      end
    end
  end

  // A write in the same cycle as a promote is forwarded so the newest descriptor wins.
  assign head_desc = push ? push_desc : stored_desc;
  assign ovf       = push && valid;

endmodule

// File: rtl/drive_enve_addr_gen.sv
// Per-bank envelope-memory address generator: latches a descriptor, streams addresses, pulses fin.
// Optional ENVE_ADDR_BOUND_CHECK_EN rejects descriptors running past ENVE_DEPTH and adds addr_err.
module drive_enve_addr_gen
  import drive_enve_pkg::*;
#(
  parameter int ENVE_ADDR_WIDTH = ENVE_ADDR_WIDTH_DEF,
  parameter int ENVE_LEN_WIDTH  = ENVE_LEN_WIDTH_DEF,
  parameter int ENVE_DEPTH      = ENVE_DEPTH_DEF
)
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       set_enve_memory_addr,
  input  logic                       start_read_addr,
  input  logic                       increment_enve_memory_addr,
  input  logic [ENVE_ADDR_WIDTH-1:0] start_addr_in,
  input  logic [ENVE_LEN_WIDTH-1:0]  env_len_in,
  output logic [ENVE_ADDR_WIDTH-1:0] enve_memory_addr,
  output logic                       valid_addr,
  output logic                       is_read_env_fin,
  output logic                       desc_armed,
  output logic                       pend_ovf
`ifdef ENVE_ADDR_BOUND_CHECK_EN
  ,
  output logic                       addr_err
`endif
);

`ifdef ENVE_ADDR_BOUND_CHECK_EN
  localparam bit BOUND_EN = 1'b1;
`else
  localparam bit BOUND_EN = 1'b0;
`endif

  enve_state_t                state;
  enve_state_t                state_next;
  enve_desc_t                 cur_desc;
  enve_desc_t                 in_desc;
  enve_desc_t                 buf_head;
  logic [ENVE_LEN_WIDTH-1:0]  rem_q;
  logic [ENVE_ADDR_WIDTH:0]   desc_end;
  logic                       set_rej;
  logic                       set_ok;
  logic                       buf_push;
  logic                       buf_pop;
  logic                       buf_valid;
  logic                       buf_ovf;
  logic                       has_pending;

  assign in_desc = {start_addr_in, env_len_in};

  // End address is formed one bit wider so a descriptor ending exactly at the depth is legal.
  assign desc_end = {1'b0, start_addr_in} + (ENVE_ADDR_WIDTH+1)'(env_len_in);
  assign set_rej  = set_enve_memory_addr && BOUND_EN
                    && (desc_end > (ENVE_ADDR_WIDTH+1)'(ENVE_DEPTH));
  assign set_ok   = set_enve_memory_addr && !set_rej;

  assign buf_push    = set_ok && ((state == READ) || (state == FIN));
  assign buf_pop     = (state == FIN);
  assign has_pending = buf_valid || buf_push;

  drive_enve_desc_buffer u_desc_buffer (
    .clk       (clk),
    .rst       (rst),
    .push      (buf_push),
    .push_desc (in_desc),
    .pop       (buf_pop),
    .valid     (buf_valid),
    .head_desc (buf_head),
    .ovf       (buf_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (set_ok) begin
          state_next = desc_is_empty(in_desc) ? FIN : ARMED;
        end
      end
      ARMED: begin
        // A rejected descriptor freezes the bank for this cycle, including any start.
        if (!set_rej) begin
          if (set_ok && desc_is_empty(in_desc)) begin
            state_next = FIN;
          end else if (start_read_addr) begin
            state_next = READ;
          end
        end
      end
      READ: begin
        if (increment_enve_memory_addr && (rem_q <= ENVE_LEN_WIDTH'(1))) begin
          state_next = FIN;
        end
      end
      FIN: begin
        if (has_pending) begin
          state_next = desc_is_empty(buf_head) ? FIN : ARMED;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_desc         <= '0;
      enve_memory_addr <= '0;
      rem_q            <= '0;
      pend_ovf         <= 1'b0;
    end else begin
      if (buf_ovf) begin
        pend_ovf <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (set_ok) begin
            cur_desc <= in_desc;
          end
        end
        ARMED: begin
          if (!set_rej) begin
            if (set_ok) begin
              cur_desc <= in_desc;
            end
            if (start_read_addr) begin
              enve_memory_addr <= set_ok ? start_addr_in : cur_desc.start;
              rem_q            <= set_ok ? env_len_in    : cur_desc.len;
            end
          end
        end
        READ: begin
          if (increment_enve_memory_addr) begin
            rem_q <= rem_q - ENVE_LEN_WIDTH'(1);
            if (rem_q > ENVE_LEN_WIDTH'(1)) begin
              enve_memory_addr <= enve_memory_addr + ENVE_ADDR_WIDTH'(1);
            end
          end
        end
        FIN: begin
          if (has_pending) begin
            cur_desc <= buf_head;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ENVE_ADDR_BOUND_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_err <= 1'b0;
    end else if (set_rej) begin
      addr_err <= 1'b1;
    end
  end
`endif

  always_comb begin
    valid_addr      = (state == READ);
    is_read_env_fin = (state == FIN);
    desc_armed      = (state == ARMED);
  end

endmodule

// File: tb/tb_drive_enve_addr_gen.sv
// Self-checking bench for drive_enve_addr_gen; consumed addresses are scored against a queue.
module tb_drive_enve_addr_gen;

  localparam int AW = 8;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          set_enve_memory_addr = 1'b0;
  logic          start_read_addr = 1'b0;
  logic          increment_enve_memory_addr = 1'b0;
  logic [AW-1:0] start_addr_in = '0;
  logic [LW-1:0] env_len_in = '0;
  logic [AW-1:0] enve_memory_addr;
  logic          valid_addr;
  logic          is_read_env_fin;
  logic          desc_armed;
  logic          pend_ovf;
`ifdef ENVE_ADDR_BOUND_CHECK_EN
  logic          addr_err;
`endif

  int checks = 0;
  int errors = 0;
  int fin_count = 0;
  int fin_before;
  logic [AW-1:0] exp_q[$];

  always #5 clk = ~clk;

  drive_enve_addr_gen dut (
    .clk                        (clk),
    .rst                        (rst),
    .set_enve_memory_addr       (set_enve_memory_addr),
    .start_read_addr            (start_read_addr),
    .increment_enve_memory_addr (increment_enve_memory_addr),
    .start_addr_in              (start_addr_in),
    .env_len_in                 (env_len_in),
    .enve_memory_addr           (enve_memory_addr),
    .valid_addr                 (valid_addr),
    .is_read_env_fin            (is_read_env_fin),
    .desc_armed                 (desc_armed),
    .pend_ovf                   (pend_ovf)
`ifdef ENVE_ADDR_BOUND_CHECK_EN
    ,
    .addr_err                   (addr_err)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", tag, actual, expected);
    end
  endtask

  // Drive one cycle of commands, let the edge take them, then release the strobes.
  task automatic applyStimulus(input logic s, input logic st, input logic inc,
                               input logic [AW-1:0] sa, input logic [LW-1:0] len);
    set_enve_memory_addr       = s;
    start_read_addr            = st;
    increment_enve_memory_addr = inc;
    start_addr_in              = sa;
    env_len_in                 = len;
    @(posedge clk);
    #1;
    set_enve_memory_addr       = 1'b0;
    start_read_addr            = 1'b0;
    increment_enve_memory_addr = 1'b0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic expectAddrs(input logic [AW-1:0] base, input int n);
    logic [AW-1:0] a;
    for (int i = 0; i < n; i++) begin
      a = base + AW'(i);
      exp_q.push_back(a);
    end
  endtask

  task automatic checkFlags(input string tag, input logic v, input logic f, input logic a);
    checkOutput({tag, "_valid"}, {31'd0, valid_addr}, {31'd0, v});
    checkOutput({tag, "_fin"}, {31'd0, is_read_env_fin}, {31'd0, f});
    checkOutput({tag, "_armed"}, {31'd0, desc_armed}, {31'd0, a});
  endtask

  // Every address the memory consumes (valid with increment) must match the scoreboard head.
  always @(negedge clk) begin
    if (!rst && valid_addr && increment_enve_memory_addr) begin
      if (exp_q.size() == 0) begin
        checkOutput("addr_unexpected", {24'd0, enve_memory_addr}, 32'h100);
      end else begin
        checkOutput("addr_stream", {24'd0, enve_memory_addr}, {24'd0, exp_q.pop_front()});
      end
    end
    if (!rst && is_read_env_fin) begin
      fin_count++;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    doReset();
    checkFlags("reset", 1'b0, 1'b0, 1'b0);
    checkOutput("reset_addr", {24'd0, enve_memory_addr}, 32'h0);
    checkOutput("reset_ovf", {31'd0, pend_ovf}, 32'h0);

    // Basic three-sample envelope with one hold cycle.
    expectAddrs(8'h10, 3);
    applyStimulus(1, 0, 0, 8'h10, 8'd3);
    checkFlags("t1_set", 1'b0, 1'b0, 1'b1);
    applyStimulus(0, 1, 0, 8'h00, 8'd0);
    checkFlags("t1_start", 1'b1, 1'b0, 1'b0);
    checkOutput("t1_first_addr", {24'd0, enve_memory_addr}, 32'h10);
    applyStimulus(0, 0, 0, 8'h00, 8'd0);
    checkOutput("t1_hold_addr", {24'd0, enve_memory_addr}, 32'h10);
    applyStimulus(0, 0, 1, 8'h00, 8'd0);
    applyStimulus(0, 0, 1, 8'h00, 8'd0);
    checkOutput("t1_third_addr", {24'd0, enve_memory_addr}, 32'h12);
    applyStimulus(0, 0, 1, 8'h00, 8'd0);
    checkFlags("t1_fin", 1'b0, 1'b1, 1'b0);
    applyStimulus(0, 0, 0, 8'h00, 8'd0);
    checkFlags("t1_idle", 1'b0, 1'b0, 1'b0);
    checkOutput("t1_q_empty", exp_q.size(), 32'd0);

    // Empty envelope in IDLE completes at once.
    applyStimulus(1, 0, 0, 8'h33, 8'd0);
    checkFlags("t2_fin", 1'b0, 1'b1, 1'b0);
    applyStimulus(0, 0, 0, 8'h00, 8'd0);
    checkFlags("t2_idle", 1'b0, 1'b0, 1'b0);

    // Pending overwrite during READ, then promotion after fin.
    doReset();
    expectAddrs(8'h60, 2);
    expectAddrs(8'h50, 1);
    applyStimulus(1, 0, 0, 8'h60, 8'd2);
    applyStimulus(0, 1, 0, 8'h00, 8'd0);
    applyStimulus(1, 0, 0, 8'h40, 8'd2);
    checkOutput("t3_ovf_first", {31'd0, pend_ovf}, 32'h0);
    applyStimulus(1, 0, 0, 8'h50, 8'd1);
    checkOutput("t3_ovf_second", {31'd0, pend_ovf}, 32'h1);
    checkOutput("t3_addr_kept", {24'd0, enve_memory_addr}, 32'h60);
    applyStimulus(0, 0, 1, 8'h00, 8'd0);
    applyStimulus(0, 0, 1, 8'h00, 8'd0);
    checkFlags("t3_fin", 1'b0, 1'b1, 1'b0);
    applyStimulus(0, 0, 0, 8'h00, 8'd0);
    checkFlags("t3_promoted", 1'b0, 1'b0, 1'b1);
    applyStimulus(0, 1, 0, 8'h00, 8'd0);
    checkOutput("t3_pend_addr", {24'd0, enve_memory_addr}, 32'h50);
    applyStimulus(0, 0, 1, 8'h00, 8'd0);
    checkFlags("t3_fin2", 1'b0, 1'b1, 1'b0);
    applyStimulus(0, 0, 0, 8'h00, 8'd0);
    checkFlags("t3_idle", 1'b0, 1'b0, 1'b0);
    checkOutput("t3_q_empty", exp_q.size(), 32'd0);

    // Descriptor crossing the top of the address space.
    doReset();
`ifdef ENVE_ADDR_BOUND_CHECK_EN
    applyStimulus(1, 0, 0, 8'hFE, 8'd4);
    checkOutput("t4_addr_err", {31'd0, addr_err}, 32'h1);
    checkFlags("t4_rejected", 1'b0, 1'b0, 1'b0);
    applyStimulus(0, 1, 0, 8'h00, 8'd0);
    checkFlags("t4_start_ignored", 1'b0, 1'b0, 1'b0);
`else
    expectAddrs(8'hFE, 4);
    applyStimulus(1, 0, 0, 8'hFE, 8'd4);
    applyStimulus(0, 1, 0, 8'h00, 8'd0);
    checkOutput("t4_first_addr", {24'd0, enve_memory_addr}, 32'hFE);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 1, 8'h00, 8'd0);
    end
    checkOutput("t4_wrapped_addr", {24'd0, enve_memory_addr}, 32'h01);
    applyStimulus(0, 0, 1, 8'h00, 8'd0);
    checkFlags("t4_fin", 1'b0, 1'b1, 1'b0);
    checkOutput("t4_q_empty", exp_q.size(), 32'd0);
`endif

    // set+start in ARMED uses the newly presented descriptor.
    doReset();
    expectAddrs(8'h30, 2);
    applyStimulus(1, 0, 0, 8'h20, 8'd2);
    applyStimulus(1, 1, 0, 8'h30, 8'd2);
    checkFlags("t5_start", 1'b1, 1'b0, 1'b0);
    checkOutput("t5_bypass_addr", {24'd0, enve_memory_addr}, 32'h30);
    applyStimulus(0, 0, 1, 8'h00, 8'd0);
    applyStimulus(0, 0, 1, 8'h00, 8'd0);
    checkFlags("t5_fin", 1'b0, 1'b1, 1'b0);
    checkOutput("t5_q_empty", exp_q.size(), 32'd0);

    // Reset in the middle of a read aborts without a fin pulse.
    doReset();
    expectAddrs(8'h70, 1);
    applyStimulus(1, 0, 0, 8'h70, 8'd5);
    applyStimulus(0, 1, 0, 8'h00, 8'd0);
    applyStimulus(0, 0, 1, 8'h00, 8'd0);
    checkOutput("t6_second_addr", {24'd0, enve_memory_addr}, 32'h71);
    fin_before = fin_count;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkFlags("t6_reset", 1'b0, 1'b0, 1'b0);
    checkOutput("t6_reset_addr", {24'd0, enve_memory_addr}, 32'h0);
    applyStimulus(0, 1, 0, 8'h00, 8'd0);
    checkFlags("t6_start_ignored", 1'b0, 1'b0, 1'b0);
    repeat (3) applyStimulus(0, 0, 0, 8'h00, 8'd0);
    checkOutput("t6_no_fin", fin_count, fin_before);
    checkOutput("t6_q_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/drive_enve_addr_gen.md
Name: drive_enve_addr_gen

Overview:
- Per-bank envelope-memory address generator in the drive circuit.
- Responder to the drive control unit's per-bank commands: set_enve_memory_addr, start_read_addr and increment_enve_memory_addr.
- Latches an envelope descriptor (start address, length), streams addresses to the envelope memory, and reports completion back to the control unit.
- Its valid_addr output feeds the control unit's valid_addr_in; is_read_env_fin feeds is_read_env_fin_in.

Parameters:
- ENVE_ADDR_WIDTH, 8, envelope memory address width.
- ENVE_LEN_WIDTH, 8, envelope length width, in samples.
- ENVE_DEPTH, 256, number of envelope memory words; used only by the bound check.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- set_enve_memory_addr  in  1  latch descriptor from start_addr_in/env_len_in this cycle.
- start_read_addr  in  1  begin streaming the armed descriptor.
- increment_enve_memory_addr  in  1  advance to the next sample address.
- start_addr_in  in  ENVE_ADDR_WIDTH  descriptor start address.
- env_len_in  in  ENVE_LEN_WIDTH  descriptor length in samples; 0 means empty envelope.
- enve_memory_addr  out  ENVE_ADDR_WIDTH  current read address (registered).
- valid_addr  out  1  enve_memory_addr is valid; high only in READ.
- is_read_env_fin  out  1  single-cycle pulse when an envelope completes.
- desc_armed  out  1  a descriptor is armed and waiting for start.
- pend_ovf  out  1  sticky flag: pending descriptor was overwritten.

Behaviour:
- Reset: state IDLE; all outputs 0; internal cur/pending descriptors, remaining count and pending-valid cleared. A reset mid-read aborts the read immediately, with no fin pulse.
- States: IDLE, ARMED, READ, FIN. All outputs are registered.
- IDLE:
  - set with len!=0 -> ARMED, latch descriptor, desc_armed=1.
  - set with len==0 -> FIN.
  - start and increment are ignored.
- ARMED:
  - set alone -> overwrite the armed descriptor (len==0 -> FIN).
  - start -> READ next cycle: enve_memory_addr=cur.start, valid_addr=1, remaining=cur.len, desc_armed=0.
  - set+start in the same cycle -> start uses the newly presented descriptor (bypass). If len==0, go to FIN.
- READ:
  - increment with remaining>1 -> addr+1 and remaining-1 at the next cycle.
  - increment with remaining==1 -> FIN, valid_addr=0.
  - No increment -> hold addr.
  - start ignored.
  - set -> store into the pending register. If pending is already valid, overwrite it (last wins) and set pend_ovf.
- FIN:
  - is_read_env_fin=1 for exactly one cycle, then:
    - pending valid -> ARMED with pending promoted, pending-valid cleared.
    - otherwise -> IDLE.
  - A set during FIN goes to pending (same overwrite rule). It is promoted in the same transition.
- Latency:
  - start at cycle N -> first valid address at N+1.
  - increment at N -> new address at N+1.
  - Last increment at N -> valid_addr low and fin pulse at N+1.
- Address arithmetic: addr+1 wraps modulo 2^ENVE_ADDR_WIDTH.
- A len of L produces exactly L valid addresses: start .. start+L-1.

Optional Feature:
- ENVE_ADDR_BOUND_CHECK_EN defined:
  - Any descriptor with start_addr_in+env_len_in > ENVE_DEPTH (computed at ENVE_ADDR_WIDTH+1 bits) is rejected: the state does not change and the pending register is not written.
  - Adds port addr_err (out, 1, sticky, reset 0), which is set on rejection.
- Undefined: no check, no addr_err port; addresses wrap.

Decomposition:
- Package drive_enve_pkg holds:
  - state enum enve_state_t {IDLE, ARMED, READ, FIN};
  - descriptor struct enve_desc_t {start, len};
  - default width constants.
- One sub-module, drive_enve_desc_buffer: the 1-deep pending descriptor register with valid, overwrite detection and pop-on-promote.

Test Plan:
- set(start=0x10,len=3), then start -> addr 0x10,0x11,0x12 with valid_addr=1 over 3 increments; valid_addr drops and fin pulses 1 cycle after the 3rd increment.
- set(len=0) in IDLE -> fin pulses next cycle; valid_addr never rises.
- In READ, set(0x40,2) then set(0x50,1) -> pend_ovf=1. After fin: ARMED with start 0x50; start -> addr 0x50, single sample.
- set(start=0xFE,len=4) with the macro off -> addresses 0xFE,0xFF,0x00,0x01. With ENVE_ADDR_BOUND_CHECK_EN -> descriptor rejected, addr_err=1, state stays IDLE.
- set+start in the same cycle in ARMED (old 0x20, new 0x30) -> first addr 0x30.
- rst asserted at the 2nd sample of a len=5 read -> next cycle all outputs 0 and IDLE, no fin pulse; a following start is ignored.
